// File: rtl/switch_debounce_if.sv
// rtl/switch_debounce_if.sv - switch debouncer signal bundle
interface switch_debounce_if;
    logic       ena;
    logic [7:0] sw_in;
    logic [7:0] sw_stable;
    logic       sw_changed;
    logic [7:0] sw_rise;
    logic [7:0] sw_fall;
    logic       busy;

    modport master (
        output ena,
        output sw_in,
        input  sw_stable,
        input  sw_changed,
        input  sw_rise,
        input  sw_fall,
        input  busy
    );

    modport slave (
        input  ena,
        input  sw_in,
        output sw_stable,
        output sw_changed,
        output sw_rise,
        output sw_fall,
        output busy
    );
endinterface

// File: rtl/switch_debounce.sv
// rtl/switch_debounce.sv - 8-bit switch debouncer with commit pulses
module switch_debounce #(
    parameter logic [23:0] DEBOUNCE_CYCLES = 24'd100_000
) (
    input logic          clk,
    input logic          rst_n,
    switch_debounce_if.slave sw
);
    typedef enum logic {IDLE, SETTLE} state_t;

    localparam logic [23:0] LAST_CNT = DEBOUNCE_CYCLES - 24'd1;

    logic [7:0]  sync1_q, sync2_q;
    state_t      state_q, state_d;
    logic [7:0]  cand_q, cand_d;
    logic [23:0] cnt_q, cnt_d;
    logic [7:0]  stable_q, stable_d;
    logic [7:0]  rise_q, rise_d;
    logic [7:0]  fall_q, fall_d;
    logic        changed_q, changed_d;

    // sw_in is asynchronous; only sync2_q is visible to the FSM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q <= 8'h00;
            sync2_q <= 8'h00;
        end else begin
            sync1_q <= sw.sw_in;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cand_q    <= 8'h00;
            cnt_q     <= 24'd0;
            stable_q  <= 8'h00;
            rise_q    <= 8'h00;
            fall_q    <= 8'h00;
            changed_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cand_q    <= cand_d;
            cnt_q     <= cnt_d;
            stable_q  <= stable_d;
            rise_q    <= rise_d;
            fall_q    <= fall_d;
            changed_q <= changed_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cand_d    = cand_q;
        cnt_d     = cnt_q;
        stable_d  = stable_q;
        rise_d    = 8'h00;
        fall_d    = 8'h00;
        changed_d = 1'b0;
        if (!sw.ena) begin
            state_d = IDLE;
            cnt_d   = 24'd0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (sync2_q != stable_q) begin
                        cand_d  = sync2_q;
                        cnt_d   = 24'd0;
                        state_d = SETTLE;
                    end
                end
                SETTLE: begin
                    if (sync2_q != cand_q) begin
                        cand_d = sync2_q;
                        cnt_d  = 24'd0;
                    end else if (cnt_q >= LAST_CNT) begin
                        // A bounce back to the old value commits silently
                        stable_d  = cand_q;
                        rise_d    = cand_q & ~stable_q;
                        fall_d    = ~cand_q & stable_q;
                        changed_d = (cand_q != stable_q);
                        cnt_d     = 24'd0;
                        state_d   = IDLE;
                    end else begin
                        cnt_d = cnt_q + 24'd1;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign sw.sw_stable  = stable_q;
    assign sw.sw_changed = changed_q;
    assign sw.sw_rise    = rise_q;
    assign sw.sw_fall    = fall_q;
    assign sw.busy       = (state_q == SETTLE);
endmodule

// File: tb/tb_switch_debounce.sv
// tb/tb_switch_debounce.sv - directed self-checking bench for switch_debounce
module tb_switch_debounce;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   n_changed = 0;
    logic [7:0] pulse_or = 8'h00;

    switch_debounce_if bus ();

    switch_debounce #(.DEBOUNCE_CYCLES(24'd4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .sw    (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each step crosses exactly one rising edge and samples at the falling edge
    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (bus.sw_changed) n_changed++;
            pulse_or = pulse_or | bus.sw_rise | bus.sw_fall;
        end
    endtask

    task automatic clear_counts();
        n_changed = 0;
        pulse_or  = 8'h00;
    endtask

    initial begin
        rst_n      = 1'b0;
        bus.ena    = 1'b1;
        bus.sw_in  = 8'h00;
        step(3);
        check("reset_outputs", {6'd0, bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed, bus.busy}, 32'd0);
        rst_n = 1'b1;
        step(3);
        check("idle_after_reset", {31'd0, bus.busy}, 32'd0);

        // 00 -> A5
        clear_counts();
        bus.sw_in = 8'hA5;
        step(2);
        check("a5_busy_edge2", {31'd0, bus.busy}, 32'd0);
        step(1);
        check("a5_busy_edge3", {31'd0, bus.busy}, 32'd1);
        step(3);
        check("a5_stable_edge6", {24'd0, bus.sw_stable}, 32'h00);
        step(1);
        check("a5_stable_edge7", {24'd0, bus.sw_stable}, 32'hA5);
        check("a5_changed", {31'd0, bus.sw_changed}, 32'd1);
        check("a5_rise", {24'd0, bus.sw_rise}, 32'hA5);
        check("a5_fall", {24'd0, bus.sw_fall}, 32'h00);
        step(1);
        check("a5_pulse_end", {23'd0, bus.sw_changed, bus.sw_rise}, 32'd0);
        check("a5_busy_end", {31'd0, bus.busy}, 32'd0);

        // A5 -> 5A
        clear_counts();
        bus.sw_in = 8'h5A;
        step(6);
        check("5a_stable_edge6", {24'd0, bus.sw_stable}, 32'hA5);
        step(1);
        check("5a_stable_edge7", {24'd0, bus.sw_stable}, 32'h5A);
        check("5a_rise", {24'd0, bus.sw_rise}, 32'h5A);
        check("5a_fall", {24'd0, bus.sw_fall}, 32'hA5);
        step(3);
        check("5a_one_pulse", n_changed, 32'd1);

        // toggling never commits, final hold commits after 7 edges
        bus.sw_in = 8'h00;
        step(10);
        check("t3_start_zero", {24'd0, bus.sw_stable}, 32'h00);
        clear_counts();
        for (int i = 0; i < 10; i++) begin
            bus.sw_in = (i % 2 == 0) ? 8'h01 : 8'h00;
            step(2);
        end
        check("toggle_no_commit", n_changed, 32'd0);
        check("toggle_stable", {24'd0, bus.sw_stable}, 32'h00);
        bus.sw_in = 8'h01;
        step(6);
        check("toggle_edge6", {24'd0, bus.sw_stable}, 32'h00);
        step(1);
        check("toggle_edge7", {24'd0, bus.sw_stable}, 32'h01);
        check("toggle_changed", {31'd0, bus.sw_changed}, 32'd1);

        // short glitch returns to original value: silent commit
        bus.sw_in = 8'h00;
        step(10);
        check("t4_start_zero", {24'd0, bus.sw_stable}, 32'h00);
        clear_counts();
        bus.sw_in = 8'h01;
        step(2);
        bus.sw_in = 8'h00;
        step(1);
        check("glitch_settle", {31'd0, bus.busy}, 32'd1);
        step(5);
        check("glitch_busy_edge8", {31'd0, bus.busy}, 32'd1);
        step(1);
        check("glitch_idle_edge9", {31'd0, bus.busy}, 32'd0);
        step(3);
        check("glitch_no_changed", n_changed, 32'd0);
        check("glitch_no_edges", {24'd0, pulse_or}, 32'd0);
        check("glitch_stable", {24'd0, bus.sw_stable}, 32'h00);

        // disabled: input ignored, enable commits 5 edges later
        clear_counts();
        bus.ena   = 1'b0;
        bus.sw_in = 8'hFF;
        step(20);
        check("dis_stable", {24'd0, bus.sw_stable}, 32'h00);
        check("dis_busy", {31'd0, bus.busy}, 32'd0);
        check("dis_no_pulse", n_changed, 32'd0);
        bus.ena = 1'b1;
        step(4);
        check("ena_edge4", {24'd0, bus.sw_stable}, 32'h00);
        step(1);
        check("ena_edge5", {24'd0, bus.sw_stable}, 32'hFF);
        check("ena_rise", {24'd0, bus.sw_rise}, 32'hFF);

        // asynchronous reset mid-settle, then clean restart
        bus.sw_in = 8'h3C;
        step(5);
        check("mid_settle_busy", {31'd0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", {6'd0, bus.sw_stable, bus.sw_rise, bus.sw_fall, bus.sw_changed, bus.busy}, 32'd0);
        step(2);
        rst_n = 1'b1;
        clear_counts();
        step(6);
        check("restart_edge6", {24'd0, bus.sw_stable}, 32'h00);
        step(1);
        check("restart_edge7", {24'd0, bus.sw_stable}, 32'h3C);
        check("restart_rise", {24'd0, bus.sw_rise}, 32'h3C);
        check("restart_fall", {24'd0, bus.sw_fall}, 32'h00);
        step(2);
        check("restart_one_pulse", n_changed, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
